// File: rtl/phy_pkg.sv
// Shared USB PD PHY definitions: K-codes, ordered-set types, 4b5b encoding and
// CRC32 constants used by both the TX framer and the RX CRC checker.
package phy_pkg;

  typedef enum logic [2:0] {
    TX_SOP        = 3'd0,
    TX_SOP_P      = 3'd1,
    TX_SOP_PP     = 3'd2,
    TX_SOP_P_DBG  = 3'd3,
    TX_SOP_PP_DBG = 3'd4,
    TX_HARD_RST   = 3'd5,
    TX_CABLE_RST  = 3'd6,
    TX_RSVD       = 3'd7
  } tx_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SOS, S_DATA, S_CRC, S_EOP, S_DONE, S_ERR
  } tx_state_e;

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    case (n)
      4'h0: enc4b5b = 5'b11110;  4'h1: enc4b5b = 5'b01001;
      4'h2: enc4b5b = 5'b10100;  4'h3: enc4b5b = 5'b10101;
      4'h4: enc4b5b = 5'b01010;  4'h5: enc4b5b = 5'b01011;
      4'h6: enc4b5b = 5'b01110;  4'h7: enc4b5b = 5'b01111;
      4'h8: enc4b5b = 5'b10010;  4'h9: enc4b5b = 5'b10011;
      4'hA: enc4b5b = 5'b10110;  4'hB: enc4b5b = 5'b10111;
      4'hC: enc4b5b = 5'b11010;  4'hD: enc4b5b = 5'b11011;
      4'hE: enc4b5b = 5'b11100;  default: enc4b5b = 5'b11101;
    endcase
  endfunction

  // Ordered-set K-code i (0 = first on the wire) for a given type.
  function automatic logic [4:0] sos_kcode(input tx_type_e t, input logic [1:0] i);
    logic [3:0][4:0] s;
    case (t)
      TX_SOP:        s = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
      TX_SOP_P:      s = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
      TX_SOP_PP:     s = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
      TX_SOP_P_DBG:  s = {K_SYNC3, K_RST2,  K_RST2,  K_SYNC1};
      TX_SOP_PP_DBG: s = {K_SYNC2, K_SYNC3, K_RST2,  K_SYNC1};
      TX_HARD_RST:   s = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
      TX_CABLE_RST:  s = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};
      default:       s = '0;
    endcase
    sos_kcode = s[i];
  endfunction

endpackage

// File: rtl/phy_crc32_nibble.sv
// Reflected CRC32, four bit-serial steps per nibble (LSB first), registered.
module phy_crc32_nibble
  import phy_pkg::*;
#(
  parameter logic [31:0] INIT = CRC_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  nibble,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = INIT;
    end else if (en) begin
      for (int i = 0; i < 4; i++)
        crc_d = (crc_d >> 1) ^ ((crc_d[0] ^ nibble[i]) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc_q <= INIT;
    else        crc_q <= crc_d;

  assign crc = crc_q;

endmodule

// File: rtl/phy_tx_packet_builder.sv
// USB PD PHY transmit framer: preamble request, SOP* K-codes, 4b5b payload,
// inverted CRC32 and EOP on a registered valid/ready symbol stream.
module phy_tx_packet_builder
  import phy_pkg::*;
#(
  parameter int          MAX_BYTES = 30,
  parameter logic [31:0] CRC_INIT  = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [2:0] tx_type,
  input  logic       tx_abort,
  output logic       tx_done,
  output logic       tx_result,
  input  logic [7:0] pl_byte,
  input  logic       pl_byte_valid,
  input  logic       pl_byte_last,
  output logic       pl_byte_ready,
  output logic       preamble_en,
  input  logic       preamble_done,
  output logic [4:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       busy
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  tx_state_e   state_q;
  tx_type_e    type_q;
  logic [2:0]  idx_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  byte_q;
  logic        last_q, hi_q, need_q;
  logic [4:0]  sym_q;
  logic        sym_valid_q, done_q, result_q, pre_en_q;

  logic        sym_acc, crc_clr, crc_en, abort_ok;
  logic [2:0]  nxt_idx;
  logic [31:0] crc, crc_inv;

  // An abort wins over an acceptance in the same cycle.
  assign sym_acc  = sym_valid_q && sym_ready && !tx_abort;
  assign abort_ok = tx_abort && state_q != S_IDLE && state_q != S_DONE && state_q != S_ERR;
  assign crc_clr  = state_q == S_IDLE && tx_start && tx_type_e'(tx_type) != TX_RSVD;
  assign crc_en   = state_q == S_DATA && sym_acc;
  assign nxt_idx  = idx_q + 3'd1;
  assign crc_inv  = ~crc;

  phy_crc32_nibble #(.INIT(CRC_INIT)) u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .nibble (hi_q ? byte_q[7:4] : byte_q[3:0]),
    .crc    (crc)
  );

  // The byte is taken in the same cycle it is offered, so ready is not registered.
  assign pl_byte_ready = state_q == S_DATA && need_q && pl_byte_valid && !tx_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;      type_q <= TX_SOP;  idx_q <= '0;
      cnt_q <= '0;            byte_q <= '0;      last_q <= 1'b0;
      hi_q <= 1'b0;           need_q <= 1'b0;    sym_q <= '0;
      sym_valid_q <= 1'b0;    done_q <= 1'b0;    result_q <= 1'b0;
      pre_en_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      result_q <= 1'b0;
      if (abort_ok) begin
        state_q <= S_ERR; sym_valid_q <= 1'b0; pre_en_q <= 1'b0;
        done_q <= 1'b1;   result_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (tx_start) begin
            if (tx_type_e'(tx_type) == TX_RSVD) begin
              done_q <= 1'b1; result_q <= 1'b1;
            end else begin
              type_q <= tx_type_e'(tx_type); state_q <= S_PRE;
              pre_en_q <= 1'b1; cnt_q <= '0;
            end
          end
          S_PRE: if (preamble_done) begin
            pre_en_q <= 1'b0; state_q <= S_SOS; idx_q <= '0;
            sym_q <= sos_kcode(type_q, 2'd0); sym_valid_q <= 1'b1;
          end
          S_SOS: if (sym_acc) begin
            if (idx_q == 3'd3) begin
              sym_valid_q <= 1'b0;
              if (type_q == TX_HARD_RST || type_q == TX_CABLE_RST) begin
                state_q <= S_DONE; done_q <= 1'b1;
              end else begin
                state_q <= S_DATA; need_q <= 1'b1;
              end
            end else begin
              idx_q <= nxt_idx; sym_q <= sos_kcode(type_q, nxt_idx[1:0]);
            end
          end
          S_DATA: if (need_q) begin
            if (pl_byte_valid) begin
              byte_q <= pl_byte; last_q <= pl_byte_last; need_q <= 1'b0; hi_q <= 1'b0;
              cnt_q <= cnt_q + CW'(1);
              sym_q <= enc4b5b(pl_byte[3:0]); sym_valid_q <= 1'b1;
            end else begin
              state_q <= S_ERR; done_q <= 1'b1; result_q <= 1'b1;
            end
          end else if (sym_acc) begin
            if (!hi_q) begin
              hi_q <= 1'b1; sym_q <= enc4b5b(byte_q[7:4]);
            end else begin
              sym_valid_q <= 1'b0;
              if (last_q) begin
                state_q <= S_CRC; idx_q <= '0;
              end else if (cnt_q == CW'(MAX_BYTES)) begin
                state_q <= S_ERR; done_q <= 1'b1; result_q <= 1'b1;
              end else begin
                need_q <= 1'b1;
              end
            end
          end
          // One bubble on entry lets the final data nibble settle into the CRC register.
          S_CRC: if (!sym_valid_q) begin
            sym_q <= enc4b5b(crc_inv[{idx_q, 2'b00} +: 4]); sym_valid_q <= 1'b1;
          end else if (sym_acc) begin
            if (idx_q == 3'd7) begin
              state_q <= S_EOP; sym_q <= K_EOP;
            end else begin
              idx_q <= nxt_idx; sym_q <= enc4b5b(crc_inv[{nxt_idx, 2'b00} +: 4]);
            end
          end
          S_EOP: if (sym_acc) begin
            state_q <= S_DONE; sym_valid_q <= 1'b0; done_q <= 1'b1;
          end
          S_DONE, S_ERR: begin
            state_q <= S_IDLE; sym_q <= '0; need_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_done     = done_q;
  assign tx_result   = result_q;
  assign preamble_en = pre_en_q;
  assign sym         = sym_q;
  assign sym_valid   = sym_valid_q;
  assign busy        = state_q != S_IDLE;

endmodule

// File: tb/tb_phy_tx_packet_builder.sv
// Randomized bench for phy_tx_packet_builder against a table/queue reference of
// the framed symbol stream and a bytewise CRC32.
module tb_phy_tx_packet_builder;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOPK = 5'b01101;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       tx_start = 0, tx_abort = 0, pl_byte_valid = 0, pl_byte_last = 0;
  logic       preamble_done = 0, sym_ready = 0;
  logic [2:0] tx_type = '0;
  logic [7:0] pl_byte = '0;
  logic       tx_done, tx_result, pl_byte_ready, preamble_en, sym_valid, busy;
  logic [4:0] sym;

  always #5 clk = ~clk;

  phy_tx_packet_builder dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_type(tx_type),
    .tx_abort(tx_abort), .tx_done(tx_done), .tx_result(tx_result),
    .pl_byte(pl_byte), .pl_byte_valid(pl_byte_valid), .pl_byte_last(pl_byte_last),
    .pl_byte_ready(pl_byte_ready), .preamble_en(preamble_en),
    .preamble_done(preamble_done), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .busy(busy)
  );

  logic [4:0] enc_tab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                               5'b01010, 5'b01011, 5'b01110, 5'b01111,
                               5'b10010, 5'b10011, 5'b10110, 5'b10111,
                               5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] sos_tab [7][4] = '{'{S1, S1, S1, S2}, '{S1, S1, S3, S3},
                                 '{S1, S3, S1, S3}, '{S1, R2, R2, S3},
                                 '{S1, R2, S3, S2}, '{R1, R1, R1, R2},
                                 '{R1, S1, R1, S3}};

  int n_chk = 0, n_err = 0;
  logic [7:0] pay [32];
  logic [4:0] got [$], expq [$];
  int done_cnt, done_res, done_cyc, abort_cyc, cyc, rdy_pulses, pre_cycles, stall_err, busy_at_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_feed(input logic [31:0] c0, input logic [7:0] b, input int nbits);
    logic [31:0] c = c0;
    for (int k = 0; k < nbits; k++)
      c = ((c[0] ^ b[k]) != 1'b0) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic build_exp(input int typ, input int nsent, input bit full);
    logic [31:0] c;
    expq.delete();
    for (int i = 0; i < 4; i++) expq.push_back(sos_tab[typ][i]);
    if (typ >= 5) return;
    c = 32'hFFFFFFFF;
    for (int b = 0; b < nsent; b++) begin
      expq.push_back(enc_tab[pay[b][3:0]]);
      expq.push_back(enc_tab[pay[b][7:4]]);
      c = crc_feed(c, pay[b], 8);
    end
    if (!full) return;
    c = ~c;
    for (int n = 0; n < 8; n++) expq.push_back(enc_tab[c[4*n +: 4]]);
    expq.push_back(EOPK);
  endtask

  task automatic cmp_seq(input string tag);
    int bad = 0;
    chk({tag, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      if (got[i] !== expq[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic idle(input int n);
    tx_start = 0; tx_abort = 0; pl_byte_valid = 0; pl_byte_last = 0;
    sym_ready = 0; preamble_done = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one packet from tx_start until tx_done (or until stop_at symbols were accepted).
  // rmode: 0 ready always, 1 ready one cycle in five, 2 random.
  task automatic run_pkt(input int typ, input int nvalid, input int last_idx, input int rmode,
                         input int abort_at, input int stop_at, input int start_again);
    int idx = 0;
    bit consumed, stalled = 0, abort_prev = 0, aborted = 0;
    logic [4:0] stall_sym = '0;
    got.delete();
    done_cnt = 0; rdy_pulses = 0; pre_cycles = 0; stall_err = 0; cyc = 0;
    done_cyc = -1; abort_cyc = -1; done_res = 0; busy_at_done = 0;
    tx_start = 1; tx_type = typ[2:0]; sym_ready = 0;
    pl_byte = pay[0]; pl_byte_valid = nvalid > 0; pl_byte_last = last_idx == 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      consumed = pl_byte_ready;
      if (pl_byte_ready) rdy_pulses++;
      if (sym_valid && sym_ready && !tx_abort) got.push_back(sym);
      if (stalled && !abort_prev && (!sym_valid || sym !== stall_sym)) stall_err++;
      stalled = sym_valid && !sym_ready; stall_sym = sym; abort_prev = tx_abort;
      if (preamble_en) pre_cycles++;
      if (tx_abort) abort_cyc = cyc;
      if (tx_done) begin
        done_cnt++; done_res = tx_result; done_cyc = cyc; busy_at_done = busy;
      end
      @(posedge clk); #1; cyc++;
      tx_start = start_again > 0 && cyc == start_again;
      if (tx_start) tx_type = 3'd6;
      tx_abort = 0;
      if (consumed) idx++;
      pl_byte = (idx < 32) ? pay[idx] : 8'h00;
      pl_byte_valid = idx < nvalid;
      pl_byte_last = idx == last_idx;
      preamble_done = preamble_en && pre_cycles >= 3;
      case (rmode)
        0: sym_ready = 1;
        1: sym_ready = (cyc % 5) == 0;
        default: sym_ready = $urandom_range(0, 1) != 0;
      endcase
      if (abort_at >= 0 && !aborted && got.size() == abort_at && sym_valid) begin
        tx_abort = 1; sym_ready = 1; aborted = 1;
      end
      if (stop_at >= 0 && got.size() == stop_at) return;
      if (done_cnt > 0) return;
    end
    chk("timeout", 0, 1);
  endtask

  initial begin
    int nb, typ;
    logic [31:0] c;
    logic [3:0] dn;
    for (int i = 0; i < 32; i++) pay[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {tx_done, tx_result, pl_byte_ready, preamble_en, sym, sym_valid, busy}, 0);
    rst_n = 1;
    idle(2);

    // SOP with header 0x0041
    pay[0] = 8'h41; pay[1] = 8'h00;
    run_pkt(0, 2, 1, 0, -1, -1, 0);
    build_exp(0, 2, 1);
    cmp_seq("sop_seq");
    chk("sop_done", done_cnt, 1);
    chk("sop_result", done_res, 0);
    chk("sop_rdy", rdy_pulses, 2);
    idle(3);

    // Hard Reset
    run_pkt(5, 0, -1, 0, -1, -1, 0);
    build_exp(5, 0, 0);
    cmp_seq("hr_seq");
    chk("hr_pre", pre_cycles > 0, 1);
    chk("hr_result", done_res, 0);
    chk("hr_rdy", rdy_pulses, 0);
    idle(3);

    // Reserved type
    run_pkt(7, 0, -1, 0, -1, -1, 0);
    chk("rsvd_cyc", done_cyc, 1);
    chk("rsvd_result", done_res, 1);
    chk("rsvd_busy", busy_at_done, 0);
    chk("rsvd_syms", got.size(), 0);
    idle(3);

    // SOP'' 30 bytes with a 1-in-5 ready
    for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
    run_pkt(2, 30, 29, 1, -1, -1, 0);
    build_exp(2, 30, 1);
    cmp_seq("max_seq");
    chk("max_count", got.size(), 73);
    chk("max_stall", stall_err, 0);
    chk("max_result", done_res, 0);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 30; i++) c = crc_feed(c, pay[i], 8);
    for (int n = 0; n < 8 && 64 + n < got.size(); n++) begin
      dn = 4'h0;
      for (int k = 0; k < 16; k++) if (enc_tab[k] == got[64 + n]) dn = 4'(k);
      c = crc_feed(c, {4'h0, dn}, 4);
    end
    chk("max_residue", c, 32'hDEBB20E3);
    idle(3);

    // Underrun at the second byte boundary
    pay[0] = 8'($urandom);
    run_pkt(1, 1, -1, 0, -1, -1, 0);
    build_exp(1, 1, 0);
    cmp_seq("under_seq");
    chk("under_result", done_res, 1);
    chk("under_rdy", rdy_pulses, 1);
    chk("under_symvld", sym_valid, 0);
    idle(3);

    // 31 bytes, no last flag
    for (int i = 0; i < 31; i++) pay[i] = 8'($urandom);
    run_pkt(0, 31, -1, 0, -1, -1, 0);
    build_exp(0, 30, 0);
    cmp_seq("over_seq");
    chk("over_rdy", rdy_pulses, 30);
    chk("over_result", done_res, 1);
    idle(3);

    // Abort during CRC coincident with an acceptance
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    run_pkt(1, 4, 3, 0, 15, -1, 0);
    build_exp(1, 4, 1);
    while (expq.size() > 15) void'(expq.pop_back());
    cmp_seq("abort_seq");
    chk("abort_result", done_res, 1);
    chk("abort_lat", done_cyc, abort_cyc + 1);
    idle(3);

    // Async reset mid-DATA
    for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
    run_pkt(0, 10, 9, 0, -1, 10, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_outs", {tx_done, tx_result, pl_byte_ready, preamble_en, sym, sym_valid, busy}, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_done) done_cnt++;
    end
    chk("midrst_nodone", done_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);

    // Random packets with random back-pressure and a stray tx_start while busy
    for (int p = 0; p < 6; p++) begin
      typ = $urandom_range(0, 4);
      nb = $urandom_range(1, 30);
      for (int i = 0; i < 32; i++) pay[i] = 8'($urandom);
      run_pkt(typ, nb, nb - 1, 2, -1, -1, $urandom_range(8, 40));
      build_exp(typ, nb, 1);
      cmp_seq("rnd_seq");
      chk("rnd_result", done_res, 0);
      chk("rnd_rdy", rdy_pulses, nb);
      chk("rnd_stall", stall_err, 0);
      idle(3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/phy_tx_packet_builder.md
Name: phy_tx_packet_builder

Overview:
- Transmit-side framer of the USB PD PHY; the TX counterpart of the RX payload/EOP/CRC path in the PHY control block.
- Started by the PHY TX control state machine. Runs the BMC preamble, emits the SOP* ordered set, and pulls payload bytes from the protocol layer.
- Emits payload as 4b5b-encoded nibbles, then appends the CRC32 and EOP.
- Output is a 5-bit symbol stream with a valid/ready handshake to the BMC serializer.

Parameters:
- MAX_BYTES, 30, maximum payload bytes per packet (2 header + 28 data); one more byte is an overrun error.
- CRC_INIT, 32'hFFFF_FFFF, CRC32 seed.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_start  input  1  1-cycle start pulse from the PHY TX control.
- tx_type  input  3  ordered-set type, sampled on tx_start: 0 SOP, 1 SOP', 2 SOP'', 3 SOP'_Debug, 4 SOP''_Debug, 5 Hard Reset, 6 Cable Reset, 7 reserved.
- tx_abort  input  1  synchronous abort.
- tx_done  output  1  1-cycle completion pulse.
- tx_result  output  1  qualifies tx_done: 0 ok, 1 error.
- pl_byte  input  8  payload byte from the protocol layer.
- pl_byte_valid  input  1  pl_byte is valid.
- pl_byte_last  input  1  marks the final payload byte.
- pl_byte_ready  output  1  byte consumed this cycle.
- preamble_en  output  1  request for the serializer to send 64 alternating preamble bits.
- preamble_done  input  1  preamble complete.
- sym  output  5  4b5b symbol, sent LSB first.
- sym_valid  output  1  sym is valid.
- sym_ready  input  1  serializer accepts sym.
- busy  output  1  high in any non-IDLE state.

Behaviour:
- Reset: state IDLE. All outputs 0; sym=5'b0, crc=CRC_INIT, byte/nibble counters 0.
- IDLE:
  - tx_start with tx_type<=6 -> latch tx_type, go to PREAMBLE.
  - tx_type=7 -> tx_done=1 and tx_result=1 on the next cycle; stay IDLE.
- PREAMBLE: preamble_en=1 until preamble_done, then go to SOS.
- SOS: four K-codes, advancing one per sym_valid&&sym_ready. Codes are Sync-1 11000, Sync-2 10001, Sync-3 00110, RST-1 00111, RST-2 11001, EOP 01101 (bit order MSB..LSB as written, LSB transmitted first).
  - SOP = S1 S1 S1 S2
  - SOP' = S1 S1 S3 S3
  - SOP'' = S1 S3 S1 S3
  - SOP'_Debug = S1 R2 R2 S3
  - SOP''_Debug = S1 R2 S3 S2
  - Hard Reset = R1 R1 R1 R2
  - Cable Reset = R1 S1 R1 S3
  - After the 4th code: types 5/6 go to DONE_OK; all others go to DATA.
- DATA:
  - At each byte boundary, a byte is needed. pl_byte_valid=0 at that point is an underrun -> ERR. Otherwise pulse pl_byte_ready for 1 cycle and latch pl_byte and pl_byte_last.
  - Send low nibble, then high nibble, each 4b5b-encoded: 0:11110 1:01001 2:10100 3:10101 4:01010 5:01011 6:01110 7:01111 8:10010 9:10011 A:10110 B:10111 C:11010 D:11011 E:11100 F:11101.
  - After the high nibble of a byte flagged last -> go to CRC.
  - Byte count reaching MAX_BYTES without last -> ERR.
- CRC engine:
  - Reflected polynomial 0xEDB88320, 4 bit-serial steps per nibble, LSB first.
  - Updated when a data nibble is accepted.
  - Seeded with CRC_INIT at tx_start.
- CRC state: send ~crc as 8 nibbles, bits[3:0] first, 4b5b-encoded; then go to EOP.
- EOP: one EOP symbol; on acceptance go to DONE_OK.
- DONE_OK: tx_done=1, tx_result=0 for 1 cycle, then IDLE.
- ERR:
  - sym_valid drops immediately; no EOP is sent.
  - tx_done=1, tx_result=1 for 1 cycle, then IDLE.
- Handshake:
  - sym/sym_valid are registered. sym holds stable while sym_valid && !sym_ready.
  - Next symbol is presented the cycle after acceptance (0-cycle bubble allowed if prefetched).
- tx_abort in any non-IDLE state -> ERR next cycle; it overrides a simultaneous sym acceptance. tx_abort in IDLE is ignored.
- tx_start while busy is ignored.
- Async reset mid-packet returns to IDLE with all outputs 0 and no tx_done.

Decomposition:
- Shared package phy_pkg:
  - K-code constants.
  - tx_type encodings.
  - 4b5b encode function.
  - CRC32 polynomial/init/residue constants, shared with the RX CRC checker.
- One sub-module, phy_crc32_nibble:
  - Inputs: clr, en, nibble.
  - Output: crc[31:0].
  - Combinational next-state plus register.

Test Plan:
1. SOP with 2-byte header 0x0041, sym_ready always 1 -> symbol sequence is:
   - 11000 11000 11000 10001
   - 01001 01010 11110 11110
   - 8 CRC symbols for ~CRC32(0x41,0x00)
   - 01101
   - then tx_done=1, tx_result=0; pl_byte_ready pulses exactly twice.
2. tx_type=5 (Hard Reset) -> preamble_en until preamble_done, then 00111 00111 00111 11001; tx_done ok; pl_byte_ready never asserted; no CRC/EOP.
3. sym_ready toggling 1-of-5 cycles on SOP'' with a 30-byte payload -> sym stable while stalled; 4+60+8+1=73 symbols accepted; CRC matches the RX checker residue.
4. pl_byte_valid=0 at the second byte boundary -> sym_valid drops, tx_done=1 and tx_result=1, return to IDLE, no EOP.
5. 31 bytes with no last flag -> ERR after the 30th byte; tx_result=1.
6. tx_abort during the CRC state, coincident with sym_ready -> tx_done/tx_result=1 next cycle. A rst_n pulse mid-DATA -> all outputs 0 and no tx_done.
